// File: rtl/gobou_lane_core.sv
// gobou_lane_core: LANES parallel fixed-point neurons sharing one pixel stream.
// A pass multiplies in_len pixel beats against per-lane weights, then a final
// bias beat adds the per-lane bias, rescales by FRAC, optionally applies ReLU,
// narrows to DWIDTH and presents the result under a valid/ready handshake.
//
// Ports:
//   clk, xrst             clock (rising edge), asynchronous active-low reset
//   start, in_len, relu_en pass request; in_len and relu_en sampled with start
//   in_valid, in_ready    pixel/weight beat handshake (also the bias beat)
//   pixel                 shared signed activation
//   weight                per-lane signed weight, lane i at [i*DWIDTH +: DWIDTH]
//   out_valid, out_ready  result handshake
//   result                per-lane signed result, packed like weight
//   busy                  high whenever the controller is not idle
//
// Build option: define GOBOU_SATURATE_EN to clamp out-of-range lane results;
// otherwise results wrap to the low DWIDTH bits.
//
// state  | meaning
// IDLE   | waiting for start
// ACCUM  | accepting pixel beats, accumulating pixel*weight per lane
// BIAS   | accepting the bias beat, computing the rescaled result
// OUTPUT | holding result until out_ready

module gobou_lane_core #(
    parameter int DWIDTH = 16,
    parameter int LANES  = 8,
    parameter int FRAC   = 8,
    parameter int LWIDTH = 10
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      start,
    input  logic [LWIDTH-1:0]         in_len,
    input  logic                      relu_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DWIDTH-1:0]         pixel,
    input  logic [LANES*DWIDTH-1:0]   weight,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DWIDTH-1:0]   result,
    output logic                      busy
);

    localparam int AWIDTH = 2*DWIDTH + LWIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUTPUT} state_t;

    state_t                     state_q, state_d;
    logic [LWIDTH-1:0]          cnt_q;
    logic                       relu_q;
    logic signed [AWIDTH-1:0]   acc_q [LANES];
    logic [LANES*DWIDTH-1:0]    result_q, result_d;
    logic signed [2*DWIDTH-1:0] prod [LANES];
    logic signed [AWIDTH:0]     sum_w [LANES];
    logic signed [AWIDTH:0]     v_w [LANES];
    logic                       beat;

`ifdef GOBOU_SATURATE_EN
    localparam logic signed [AWIDTH:0] SAT_MAX = {{(AWIDTH+2-DWIDTH){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH:0] SAT_MIN = {{(AWIDTH+2-DWIDTH){1'b1}}, {(DWIDTH-1){1'b0}}};
`endif

    assign beat = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (in_len == '0) ? S_BIAS : S_ACCUM;
            S_ACCUM:  if (beat && cnt_q == LWIDTH'(1)) state_d = S_BIAS;
            S_BIAS:   if (beat) state_d = S_OUTPUT;
            S_OUTPUT: if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state_q == S_ACCUM) || (state_q == S_BIAS);
        out_valid = (state_q == S_OUTPUT);
        busy      = (state_q != S_IDLE);
    end

    // Per-lane products and bias/rescale path. The sum carries one extra bit
    // so adding the shifted bias to a near-full accumulator cannot overflow.
    always_comb begin
        result_d = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i]  = (2*DWIDTH)'($signed(pixel)) *
                       (2*DWIDTH)'($signed(weight[i*DWIDTH +: DWIDTH]));
            sum_w[i] = (AWIDTH+1)'(acc_q[i]) +
                       ((AWIDTH+1)'($signed(weight[i*DWIDTH +: DWIDTH])) <<< FRAC);
            v_w[i]   = sum_w[i] >>> FRAC;
            if (relu_q && v_w[i][AWIDTH]) v_w[i] = '0;
`ifdef GOBOU_SATURATE_EN
            if (v_w[i] > SAT_MAX)
                result_d[i*DWIDTH +: DWIDTH] = {1'b0, {(DWIDTH-1){1'b1}}};
            else if (v_w[i] < SAT_MIN)
                result_d[i*DWIDTH +: DWIDTH] = {1'b1, {(DWIDTH-1){1'b0}}};
            else
                result_d[i*DWIDTH +: DWIDTH] = DWIDTH'(v_w[i]);
`else
            result_d[i*DWIDTH +: DWIDTH] = DWIDTH'(v_w[i]);
`endif
        end
    end

    // Datapath: counter, latched config, accumulators, result register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            cnt_q    <= '0;
            relu_q   <= 1'b0;
            result_q <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    cnt_q  <= in_len;
                    relu_q <= relu_en;
                    for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
                end
                S_ACCUM: if (beat) begin
                    cnt_q <= cnt_q - LWIDTH'(1);
                    for (int i = 0; i < LANES; i++)
                        acc_q[i] <= acc_q[i] + AWIDTH'(prod[i]);
                end
                S_BIAS: if (beat) result_q <= result_d;
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_gobou_lane_core.sv
module tb_gobou_lane_core;

    localparam int DW = 16;
    localparam int LN = 8;
    localparam int LW = 10;
    localparam int BW = LN*DW;

    logic          clk = 1'b0;
    logic          xrst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] in_len = '0;
    logic          relu_en = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] pixel = '0;
    logic [BW-1:0] weight = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] result;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    gobou_lane_core #(.DWIDTH(DW), .LANES(LN), .FRAC(8), .LWIDTH(LW)) dut (
        .clk(clk), .xrst(xrst), .start(start), .in_len(in_len), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel), .weight(weight),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] fill(input logic [DW-1:0] v);
        logic [BW-1:0] r;
        for (int i = 0; i < LN; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    // All tasks begin and end on a falling edge.
    task automatic start_pass(input logic [LW-1:0] len, input logic relu);
        start = 1'b1; in_len = len; relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", BW'(busy), BW'(1));
    endtask

    task automatic beat(input logic [DW-1:0] pix, input logic [BW-1:0] w);
        check("in_ready_beat", BW'(in_ready), BW'(1));
        in_valid = 1'b1; pixel = pix; weight = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic bias_beat(input logic [BW-1:0] b);
        check("ov_before_bias", BW'(out_valid), BW'(0));
        beat(16'h3039, b);
        check("ov_latency1", BW'(out_valid), BW'(1));
    endtask

    task automatic take_result(input string tag, input logic [BW-1:0] exp);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("out_valid_timeout", BW'(out_valid), BW'(1));
        check(tag, result, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ov_fall", BW'(out_valid), BW'(0));
        check("idle_after_out", BW'(busy), BW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] w;
        logic [BW-1:0] e;

        // Reset state
        #1;
        check("rst_out_valid", BW'(out_valid), BW'(0));
        check("rst_in_ready", BW'(in_ready), BW'(0));
        check("rst_busy", BW'(busy), BW'(0));
        check("rst_result", result, '0);
        repeat (3) @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);

        // Basic pass, plus a start pulse during ACCUM that must be ignored
        start_pass(10'd3, 1'b0);
        beat(16'd256, fill(16'd512));
        start = 1'b1; in_len = '0; relu_en = 1'b1;
        @(negedge clk);
        start = 1'b0; relu_en = 1'b0;
        check("busy_accum", BW'(busy), BW'(1));
        beat(16'd256, fill(16'd512));
        beat(16'd256, fill(16'd512));
        bias_beat(fill(16'd256));
        take_result("basic_1792", fill(16'd1792));

        // Negative result, relu off then on
        w = '0; w[DW-1:0] = 16'hFE00;
        e = '0; e[DW-1:0] = 16'hFE00;
        start_pass(10'd1, 1'b0);
        beat(16'd256, w);
        bias_beat('0);
        take_result("neg_norelu", e);
        start_pass(10'd1, 1'b1);
        beat(16'd256, w);
        bias_beat('0);
        take_result("neg_relu", '0);

        // Overflow of the narrowed result
        start_pass(10'd4, 1'b0);
        repeat (4) beat(16'd32767, fill(16'd32767));
        bias_beat('0);
`ifdef GOBOU_SATURATE_EN
        take_result("overflow_sat", fill(16'h7FFF));
`else
        take_result("overflow_wrap", fill(16'hFC00));
`endif

        // Gapped beats and backpressured output
        start_pass(10'd3, 1'b0);
        beat(16'd256, fill(16'd512));
        @(negedge clk);
        beat(16'd256, fill(16'd512));
        @(negedge clk);
        beat(16'd256, fill(16'd512));
        bias_beat(fill(16'd256));
        for (int k = 0; k < 5; k++) begin
            check("hold_ov", BW'(out_valid), BW'(1));
            check("hold_result", result, fill(16'd1792));
            in_valid = 1'b1;
            check("no_ready_in_output", BW'(in_ready), BW'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1; start = 1'b1; in_len = 10'd2;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        check("ov_fall_bp", BW'(out_valid), BW'(0));
        check("start_at_handshake_ignored", BW'(busy), BW'(0));
        check("result_kept", result, fill(16'd1792));

        // Reset mid-pass, then a fresh pass right after release
        start_pass(10'd5, 1'b0);
        beat(16'd256, fill(16'd512));
        beat(16'd256, fill(16'd512));
        xrst = 1'b0;
        #1;
        check("midrst_busy", BW'(busy), BW'(0));
        check("midrst_in_ready", BW'(in_ready), BW'(0));
        check("midrst_result", result, '0);
        @(negedge clk);
        xrst = 1'b1;
        start_pass(10'd1, 1'b0);
        beat(16'd256, fill(16'd256));
        bias_beat('0);
        take_result("after_reset_256", fill(16'd256));

        // Zero-length pass with a start pulse that must be ignored
        start_pass(10'd0, 1'b0);
        check("len0_in_ready", BW'(in_ready), BW'(1));
        start = 1'b1; in_len = 10'd7; relu_en = 1'b1;
        @(negedge clk);
        start = 1'b0; relu_en = 1'b0;
        bias_beat(fill(16'd100));
        take_result("len0_bias100", fill(16'd100));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
